// File: rtl/conv_window_gen.sv
// ---------------------------------------------------------------------------
// conv_window_gen
//   Turns a raster-order pixel stream into 3x3 sliding windows for a
//   convolution stage. Two line buffers keep the previous two image rows.
//   Two column registers keep the last two columns of the window. Together
//   with the incoming pixel they form the full 3x3 neighbourhood. A window is
//   emitted for every accepted pixel whose row and column are both >= 2.
//
// Ports
//   clk       clock, all state changes on the rising edge
//   rst       synchronous active-high reset
//   s_valid   upstream pixel valid
//   s_ready   block can accept a pixel (= !m_valid | m_ready)
//   s_pixel   pixel value, raster order
//   s_sof     start of frame; the qualified pixel is treated as (0,0)
//   m_valid   window valid
//   m_ready   downstream accepts the window
//   m_window  3x3 window; slice k holds pixel (row+k/3, col+k%3), k=0 at LSB
//   m_row     feature-map row of the window (top-left pixel row)
//   m_col     feature-map column of the window (top-left pixel column)
//   m_last    final window of the frame
// ---------------------------------------------------------------------------
module conv_window_gen #(
  parameter int IMG_SIZE = 7,
  parameter int PIX_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [PIX_W-1:0]   s_pixel,
  input  logic               s_sof,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [9*PIX_W-1:0] m_window,
  output logic [2:0]         m_row,
  output logic [2:0]         m_col,
  output logic               m_last
);

  localparam int CW = $clog2(IMG_SIZE);
  localparam logic [CW-1:0] LAST_POS = CW'(IMG_SIZE - 1);
  localparam logic [CW-1:0] TWO      = CW'(2);

  // Pixel position of the next accepted pixel.
  logic [CW-1:0] r, c;
  // Effective position of the pixel on the input this cycle (s_sof forces 0,0).
  logic [CW-1:0] pr, pc;

  // Line buffers indexed by column: lb0 holds row r-2, lb1 holds row r-1.
  logic [PIX_W-1:0] lb0 [IMG_SIZE];
  logic [PIX_W-1:0] lb1 [IMG_SIZE];

  // Older two window columns: a = column c-2, b = column c-1 (top/mid/bottom).
  logic [PIX_W-1:0] a_top, a_mid, a_bot;
  logic [PIX_W-1:0] b_top, b_mid, b_bot;

  logic             accept;
  logic             win_en;
  logic [PIX_W-1:0] top, mid;

  assign s_ready = !m_valid || m_ready;
  assign accept  = s_valid && s_ready;

  // NOTE: every signal assigned in always_comb gets a default first so that
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    pr = r;
    pc = c;
    if (s_sof) begin
      pr = '0;
      pc = '0;
    end
  end

  assign top    = lb0[pc];
  assign mid    = lb1[pc];
  // Windows need two full rows and two full columns to the upper left. The
  // column registers refill completely at c=0..1 of every row, so data
  // from the previous row or frame is overwritten before it can be emitted.
  assign win_en = accept && (pr >= TWO) && (pc >= TWO);

  // NOTE: line buffers and column registers are deliberately not reset; they
  // are always rewritten by the current frame before any window uses them,
  // which keeps them plain RAM/flops without a reset network.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0[pc] <= mid;
      lb1[pc] <= s_pixel;
      a_top   <= b_top;
      a_mid   <= b_mid;
      a_bot   <= b_bot;
      b_top   <= top;
      b_mid   <= mid;
      b_bot   <= s_pixel;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r        <= '0;
      c        <= '0;
      m_valid  <= 1'b0;
      m_window <= '0;
      m_row    <= '0;
      m_col    <= '0;
      m_last   <= 1'b0;
    end else begin
      if (accept) begin
        if (pc == LAST_POS) begin
          c <= '0;
          r <= (pr == LAST_POS) ? '0 : pr + 1'b1;
        end else begin
          c <= pc + 1'b1;
          r <= pr;
        end
      end

      if (win_en) begin
        m_valid  <= 1'b1;
        m_window <= {s_pixel, b_bot, a_bot,
                     mid,     b_mid, a_mid,
                     top,     b_top, a_top};
        m_row    <= 3'(pr - TWO);
        m_col    <= 3'(pc - TWO);
        m_last   <= (pr == LAST_POS) && (pc == LAST_POS);
      end else if (m_ready) begin
        m_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// ---------------------------------------------------------------------------
// tb_conv_window_gen
//   Directed stimulus for conv_window_gen. A reference model keeps the
//   accepted image in a 2-D array. For every accepted pixel at row>=2 and
//   col>=2 it queues the expected window, built directly from that array.
//   A compare process checks handshake, stability and window contents on
//   every cycle. Literal expectations pin a few windows and the counts.
// ---------------------------------------------------------------------------
module tb_conv_window_gen;

  localparam int IMG = 7;
  localparam int PW  = 4;
  localparam int WW  = 9 * PW;

  logic          clk;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [PW-1:0] s_pixel;
  logic          s_sof;
  logic          m_valid;
  logic          m_ready;
  logic [WW-1:0] m_window;
  logic [2:0]    m_row;
  logic [2:0]    m_col;
  logic          m_last;

  conv_window_gen #(.IMG_SIZE(IMG), .PIX_W(PW)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_pixel  (s_pixel),
    .s_sof    (s_sof),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_window (m_window),
    .m_row    (m_row),
    .m_col    (m_col),
    .m_last   (m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WW-1:0] win;
    int            row;
    int            col;
    bit            last;
  } win_t;

  win_t          exp_q[$];
  logic [WW-1:0] got_q[$];
  logic [PW-1:0] img [IMG][IMG];
  int            errors = 0;
  int            checks = 0;
  int            win_cnt = 0;
  int            last_cnt = 0;
  int            stall_seen = 0;
  int            mr = 0;
  int            mc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [WW-1:0] pk(input int v0, input int v1, input int v2,
                                       input int v3, input int v4, input int v5,
                                       input int v6, input int v7, input int v8);
    logic [WW-1:0] w;
    w = '0;
    w[0*PW +: PW] = PW'(v0); w[1*PW +: PW] = PW'(v1); w[2*PW +: PW] = PW'(v2);
    w[3*PW +: PW] = PW'(v3); w[4*PW +: PW] = PW'(v4); w[5*PW +: PW] = PW'(v5);
    w[6*PW +: PW] = PW'(v6); w[7*PW +: PW] = PW'(v7); w[8*PW +: PW] = PW'(v8);
    return w;
  endfunction

  // Expected window whose bottom-right pixel is (r,c).
  function automatic win_t model_win(input int r, input int c);
    win_t e;
    e.win = '0;
    for (int k = 0; k < 9; k++)
      e.win[k*PW +: PW] = img[r-2+k/3][c-2+k%3];
    e.row  = r - 2;
    e.col  = c - 2;
    e.last = (r == IMG-1) && (c == IMG-1);
    return e;
  endfunction

  // Compare process: samples at the falling edge, i.e. what the next rising
  // edge will act on.
  task automatic monitor();
    bit   hold;
    win_t held;
    win_t e;
    hold = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        mr   = 0;
        mc   = 0;
        hold = 0;
      end else begin
        check("s_ready_rule", s_ready, !m_valid || m_ready);
        if (hold) begin
          check("stall_valid",  m_valid,  1);
          check("stall_window", m_window, held.win);
          check("stall_row",    m_row,    held.row);
          check("stall_col",    m_col,    held.col);
          check("stall_last",   m_last,   held.last);
        end
        hold      = m_valid && !m_ready;
        held.win  = m_window;
        held.row  = m_row;
        held.col  = m_col;
        held.last = m_last;
        if (m_valid && !m_ready) stall_seen++;

        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_window", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("window", m_window, e.win);
            check("row",    m_row,    e.row);
            check("col",    m_col,    e.col);
            check("last",   m_last,   e.last);
          end
          got_q.push_back(m_window);
          win_cnt++;
          if (m_last) last_cnt++;
        end

        if (s_valid && s_ready) begin
          if (s_sof) begin
            mr = 0;
            mc = 0;
          end
          img[mr][mc] = s_pixel;
          if (mr >= 2 && mc >= 2) exp_q.push_back(model_win(mr, mc));
          if (mc == IMG-1) begin
            mc = 0;
            mr = (mr == IMG-1) ? 0 : mr + 1;
          end else begin
            mc = mc + 1;
          end
        end
      end
    end
  endtask

  // mode 0: m_ready=1; mode 1: stall the first window 5 cycles; mode 2: random.
  task automatic run_frame(input int n, input int base, input bit sof_first, input int mode);
    int sent;
    int cyc;
    int stalls;
    sent = 0; cyc = 0; stalls = 0;
    while (sent < n && cyc < 2000) begin
      @(posedge clk); #1;
      s_valid = (mode == 2) ? ($urandom_range(0, 2) != 0) : 1'b1;
      s_pixel = PW'((base + sent) % 16);
      s_sof   = sof_first && (sent == 0);
      if (mode == 1) begin
        if (m_valid && stalls < 5) begin
          m_ready = 1'b0;
          stalls++;
        end else begin
          m_ready = 1'b1;
        end
      end else if (mode == 2) begin
        m_ready = 1'($urandom_range(0, 1));
      end else begin
        m_ready = 1'b1;
      end
      @(negedge clk);
      if (s_valid && s_ready) sent++;
      cyc++;
    end
    check("frame_send_budget", sent, n);
  endtask

  task automatic drain(input int mode);
    bit done;
    done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge clk); #1;
      s_valid = 1'b0;
      s_sof   = 1'b0;
      m_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (!m_valid && exp_q.size() == 0) done = 1;
    end
    check("drain_budget", done, 1);
  endtask

  initial begin
    int w0;
    int l0;
    int s0;
    rst = 1'b1; s_valid = 1'b0; s_pixel = '0; s_sof = 1'b0; m_ready = 1'b1;
    fork
      monitor();
    join_none
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_m_valid",  m_valid,  0);
    check("reset_m_window", m_window, 0);
    check("reset_m_row",    m_row,    0);
    check("reset_m_col",    m_col,    0);
    check("reset_m_last",   m_last,   0);
    check("reset_s_ready",  s_ready,  1);

    // Single frame, value = index mod 16, always ready.
    w0 = got_q.size(); l0 = last_cnt;
    run_frame(49, 0, 0, 0);
    drain(0);
    check("f1_count",     got_q.size() - w0, 25);
    check("f1_last_cnt",  last_cnt - l0, 1);
    if (got_q.size() >= w0 + 25) begin
      check("f1_first_win", got_q[w0],      pk(0, 1, 2, 7, 8, 9, 14, 15, 0));
      check("f1_win_0_1",   got_q[w0 + 1],  pk(1, 2, 3, 8, 9, 10, 15, 0, 1));
      check("f1_win_4_4",   got_q[w0 + 24], pk(0, 1, 2, 7, 8, 9, 14, 15, 0));
    end

    // First window stalled for 5 cycles.
    w0 = got_q.size(); s0 = stall_seen;
    run_frame(49, 0, 0, 1);
    drain(0);
    check("stall_count", got_q.size() - w0, 25);
    check("stall_cycles", stall_seen - s0, 5);
    if (got_q.size() >= w0 + 1)
      check("stall_first_win", got_q[w0], pk(0, 1, 2, 7, 8, 9, 14, 15, 0));

    // Random input gaps and random m_ready.
    w0 = got_q.size(); l0 = last_cnt;
    run_frame(49, 0, 0, 2);
    drain(2);
    check("rand_count",    got_q.size() - w0, 25);
    check("rand_last_cnt", last_cnt - l0, 1);

    // 20-pixel partial frame (reaches row 2, columns 2..5 -> 4 windows),
    // then s_sof restarts with a full frame offset by 3.
    w0 = got_q.size();
    run_frame(20, 0, 0, 0);
    run_frame(49, 3, 1, 0);
    drain(0);
    check("sof_count", got_q.size() - w0, 29);
    if (got_q.size() >= w0 + 5)
      check("sof_first_new_win", got_q[w0 + 4], pk(3, 4, 5, 10, 11, 12, 1, 2, 3));

    // Reset with a window pending (pixel 30 = (4,2) produces one).
    run_frame(31, 0, 1, 0);
    @(posedge clk); #1;
    check("pre_rst_m_valid", m_valid, 1);
    rst = 1'b1; s_valid = 1'b0; s_sof = 1'b0; m_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_m_valid",  m_valid,  0);
    check("rst_mid_s_ready",  s_ready,  1);
    check("rst_mid_m_window", m_window, 0);
    @(posedge clk); #1;
    rst = 1'b0; m_ready = 1'b1;
    w0 = got_q.size();
    run_frame(49, 0, 0, 0);
    drain(0);
    check("post_rst_count", got_q.size() - w0, 25);
    if (got_q.size() >= w0 + 1)
      check("post_rst_first_win", got_q[w0], pk(0, 1, 2, 7, 8, 9, 14, 15, 0));

    // Two back-to-back frames, second with value (index+5) mod 16.
    w0 = got_q.size(); l0 = last_cnt;
    run_frame(49, 0, 0, 0);
    run_frame(49, 5, 0, 0);
    drain(0);
    check("b2b_count",    got_q.size() - w0, 50);
    check("b2b_last_cnt", last_cnt - l0, 2);
    if (got_q.size() >= w0 + 26) begin
      check("b2b_f2_k0",  got_q[w0 + 25][PW-1:0], 5);
      check("b2b_f2_win", got_q[w0 + 25], pk(5, 6, 7, 12, 13, 14, 3, 4, 5));
    end

    check("model_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
